// File: rtl/gaussian_octave_stream.sv
// Streaming 3x3 Gaussian blur (edge-clamped) with optional 2x decimation for one pyramid octave.
// Latency: result valid 2 cycles after the pixel transfer that completes its window.
// Backpressure: two-stage result pipeline; s_ready_out drops whenever a new result could not be retired.
module gaussian_octave_stream #(
  parameter int IMG_W     = 128,
  parameter int IMG_H     = 128,
  parameter int BIT_DEPTH = 8,
  parameter int XW        = $clog2(IMG_W),
  parameter int YW        = $clog2(IMG_H)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [BIT_DEPTH-1:0] s_data_in,
  input  logic                 s_valid_in,
  output logic                 s_ready_out,
  input  logic                 ds_en_in,
  input  logic                 abort_in,
  output logic [BIT_DEPTH-1:0] m_data_out,
  output logic [XW-1:0]        m_x_out,
  output logic [YW-1:0]        m_y_out,
  output logic                 m_valid_out,
  input  logic                 m_ready_in,
  output logic                 m_last_out,
  output logic                 frame_done_out,
  output logic                 busy_out
);

  localparam int SW = BIT_DEPTH + 4;
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [XW-1:0] X_PEN = XW'(IMG_W - 2);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_PEN = YW'(IMG_H - 2);

  // One vertical slice of the 3x3 window: top, middle, bottom rows.
  typedef struct packed {
    logic [BIT_DEPTH-1:0] t;
    logic [BIT_DEPTH-1:0] m;
    logic [BIT_DEPTH-1:0] b;
  } col_t;

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_STREAM, S_FLUSH, S_DONE} state_t;

  state_t               state;
  logic [XW-1:0]        cnt_x;
  logic [YW-1:0]        cnt_y;
  logic [BIT_DEPTH-1:0] lb_a [IMG_W];  // most recent complete row
  logic [BIT_DEPTH-1:0] lb_b [IMG_W];  // row before that
  col_t                 col_m1, col_m2, col_new;
  logic                 pend_extra, flush_fed, ds_mode;
  logic [YW-1:0]        extra_row;

  logic                 p1_vld, p1_keep, p1_last;
  logic [BIT_DEPTH-1:0] p1_dat;
  logic [XW-1:0]        p1_x;
  logic [YW-1:0]        p1_y;

  logic                 in_phase, p1_move, can_feed, xfer, flush_feed, feed, extra_go;
  logic                 feed_emits, gen;
  col_t                 bl, bc, br;
  logic [XW-1:0]        rx;
  logic [YW-1:0]        ry;
  logic                 r_keep, r_last;
  logic [BIT_DEPTH-1:0] r_dat;

  function automatic logic [BIT_DEPTH-1:0] blur(col_t l, col_t c, col_t r);
    logic [SW-1:0] s;
    s = SW'(l.t) + SW'(r.t) + SW'(l.b) + SW'(r.b)
      + (SW'(c.t) << 1) + (SW'(c.b) << 1) + (SW'(l.m) << 1) + (SW'(r.m) << 1)
      + (SW'(c.m) << 2) + SW'(8);
    return s[SW-1:4];
  endfunction

  // A discarded (decimated-away) result leaves stage 1 without touching the output register.
  assign in_phase   = (state == S_IDLE) || (state == S_FILL) || (state == S_STREAM);
  assign p1_move    = p1_vld && (!p1_keep || !m_valid_out || m_ready_in);
  assign can_feed   = !p1_vld || p1_move;
  assign s_ready_out = in_phase && !pend_extra && can_feed;
  assign xfer       = s_valid_in && s_ready_out && !abort_in;
  assign flush_feed = (state == S_FLUSH) && !pend_extra && !flush_fed && can_feed && !abort_in;
  assign feed       = xfer || flush_feed;
  assign extra_go   = pend_extra && can_feed && !abort_in;
  assign feed_emits = feed && (cnt_x != '0) && ((state == S_FLUSH) || (cnt_y != '0));
  assign gen        = extra_go || feed_emits;

  // Build the incoming column, clamping the top row on the first output row and the bottom row on flush.
  always_comb begin
    col_new = '0;
    if (state == S_FLUSH) begin
      col_new.t = lb_b[cnt_x];
      col_new.m = lb_a[cnt_x];
      col_new.b = lb_a[cnt_x];
    end else begin
      col_new.t = (cnt_y == YW'(1)) ? lb_a[cnt_x] : lb_b[cnt_x];
      col_new.m = lb_a[cnt_x];
      col_new.b = s_data_in;
    end
  end

  // Pick window columns and output coordinates; right edge and left edge clamp by column reuse.
  always_comb begin
    bl = col_m2;
    bc = col_m1;
    br = col_new;
    rx = cnt_x - XW'(1);
    ry = (state == S_FLUSH) ? Y_MAX : (cnt_y - YW'(1));
    if (extra_go) begin
      br = col_m1;
      rx = X_MAX;
      ry = extra_row;
    end else if (cnt_x == XW'(1)) begin
      bl = col_m1;
    end
    r_dat  = blur(bl, bc, br);
    r_keep = !ds_mode || (!rx[0] && !ry[0]);
    r_last = ds_mode ? ((rx == X_PEN) && (ry == Y_PEN)) : ((rx == X_MAX) && (ry == Y_MAX));
  end

  // Line buffers shift one row per accepted pixel; never cleared since clamping hides stale rows.
  always_ff @(posedge clk_in) begin
    if (xfer) begin
      lb_b[cnt_x] <= lb_a[cnt_x];
      lb_a[cnt_x] <= s_data_in;
    end
  end

  // Frame sequencing: pixel counters, column window, end-of-row extra result, flush and done.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= S_IDLE;
      cnt_x          <= '0;
      cnt_y          <= '0;
      col_m1         <= '0;
      col_m2         <= '0;
      pend_extra     <= 1'b0;
      flush_fed      <= 1'b0;
      extra_row      <= '0;
      ds_mode        <= 1'b0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
    end else if (abort_in) begin
      state          <= S_IDLE;
      cnt_x          <= '0;
      cnt_y          <= '0;
      pend_extra     <= 1'b0;
      flush_fed      <= 1'b0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      frame_done_out <= 1'b0;
      if (feed) begin
        col_m2 <= col_m1;
        col_m1 <= col_new;
        if (cnt_x == X_MAX) begin
          cnt_x      <= '0;
          pend_extra <= (state == S_FLUSH) || (cnt_y != '0);
          extra_row  <= (state == S_FLUSH) ? Y_MAX : (cnt_y - YW'(1));
          if (state == S_FLUSH) flush_fed <= 1'b1;
          else                  cnt_y     <= (cnt_y == Y_MAX) ? '0 : (cnt_y + YW'(1));
        end else begin
          cnt_x <= cnt_x + XW'(1);
        end
      end
      if (extra_go) pend_extra <= 1'b0;
      case (state)
        S_IDLE: if (xfer) begin
          state    <= S_FILL;
          busy_out <= 1'b1;
          ds_mode  <= ds_en_in;
        end
        S_FILL: if (xfer && (cnt_x == XW'(1)) && (cnt_y == YW'(1))) state <= S_STREAM;
        S_STREAM: if (xfer && (cnt_x == X_MAX) && (cnt_y == Y_MAX)) state <= S_FLUSH;
        S_FLUSH: if (flush_fed && !pend_extra && !p1_vld && !m_valid_out) begin
          state          <= S_DONE;
          flush_fed      <= 1'b0;
          busy_out       <= 1'b0;
          frame_done_out <= 1'b1;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Result pipeline: stage 1 holds the computed pixel, output register holds it until accepted.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      p1_vld      <= 1'b0;
      p1_keep     <= 1'b0;
      p1_last     <= 1'b0;
      p1_dat      <= '0;
      p1_x        <= '0;
      p1_y        <= '0;
      m_valid_out <= 1'b0;
      m_data_out  <= '0;
      m_x_out     <= '0;
      m_y_out     <= '0;
      m_last_out  <= 1'b0;
    end else if (abort_in) begin
      p1_vld      <= 1'b0;
      m_valid_out <= 1'b0;
      m_last_out  <= 1'b0;
    end else begin
      if (gen) begin
        p1_vld  <= 1'b1;
        p1_dat  <= r_dat;
        p1_x    <= ds_mode ? (rx >> 1) : rx;
        p1_y    <= ds_mode ? (ry >> 1) : ry;
        p1_keep <= r_keep;
        p1_last <= r_last;
      end else if (p1_move) begin
        p1_vld <= 1'b0;
      end
      if (p1_move && p1_keep) begin
        m_valid_out <= 1'b1;
        m_data_out  <= p1_dat;
        m_x_out     <= p1_x;
        m_y_out     <= p1_y;
        m_last_out  <= p1_last;
      end else if (m_valid_out && m_ready_in) begin
        m_valid_out <= 1'b0;
        m_last_out  <= 1'b0;
      end
    end
  end

endmodule
